// File: rtl/addr4u_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addr4u_pkg : shared types and sizing helpers for the addr4u adder family    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package addr4u_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int ADDR4U_W = 4;

  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr4u_fsub_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addr4u_fsub_cell : 1-bit full subtractor, d = s - a - bin                    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module addr4u_fsub_cell (
  input  logic i_s,
  input  logic i_a,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_s ^ i_a ^ i_bin;
  assign o_bout = (~i_s & i_a) | (~(i_s ^ i_a) & i_bin);

endmodule
`default_nettype wire

// File: rtl/addr4u_serial_unadd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | addr4u_serial_unadd : bit-serial B = S - A recovery with legality flag.      |
// | Optional macro RECHECK_EN adds a CHECK state that re-adds A + B vs S.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module addr4u_serial_unadd
  import addr4u_pkg::*;
#(
  parameter int W = ADDR4U_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   sum_i,
  input  logic [W-1:0] a_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] b_o,
  output logic         err_o,
  output logic         mismatch_o
);

  localparam int SW    = sum_width(W);
  localparam int CNT_W = $clog2(SW);

  state_e           r_state;
  state_e           w_next;
  logic [SW-1:0]    r_s_sh;
  logic [SW-1:0]    r_a_sh;
  logic [W-1:0]     r_d;
  logic [W-1:0]     r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_err;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bout;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;

  assign w_accept = (r_state == IDLE) && in_valid && r_in_ready;
  assign w_last   = (r_cnt == CNT_W'(W));

  addr4u_fsub_cell u_cell (
    .i_s    (r_s_sh[0]),
    .i_a    (r_a_sh[0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next = SHIFT;
`ifdef RECHECK_EN
      SHIFT: if (w_last) w_next = CHECK;
      CHECK: w_next = DONE;
`else
      SHIFT: if (w_last) w_next = DONE;
`endif
      DONE:  if (r_out_valid && out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready_nxt  = (w_next == IDLE);
    w_out_valid_nxt = (w_next == DONE);
  end

  // Shift regs rotate, so after W+1 steps they hold the original S and {0,A} again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_sh      <= '0;
      r_a_sh      <= '0;
      r_d         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_s_sh   <= sum_i;
            r_a_sh   <= {1'b0, a_i};
            r_d      <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
          end
        end
        SHIFT: begin
          r_s_sh   <= {r_s_sh[0], r_s_sh[SW-1:1]};
          r_a_sh   <= {r_a_sh[0], r_a_sh[SW-1:1]};
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_b   <= r_d;
            r_err <= w_bout | w_d;
          end else begin
            r_d <= {w_d, r_d[W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RECHECK_EN
  logic          r_mismatch;
  logic [SW-1:0] w_recheck;

  assign w_recheck = {1'b0, r_a_sh[W-1:0]} + {1'b0, r_b};

  always_ff @(posedge clk) begin
    if (!rst_n)                  r_mismatch <= 1'b0;
    else if (r_state == CHECK)   r_mismatch <= (w_recheck != r_s_sh) && !r_err;
  end

  assign mismatch_o = r_mismatch;
`else
  assign mismatch_o = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign b_o       = r_b;
  assign err_o     = r_err;

endmodule
`default_nettype wire
